// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared types and constants for the SPI transfer scheduler.
// Holds the FSM state enum, SPI core register offsets, ctrl bit positions,
// the APB step encoding and a helper that assembles the ctrl word.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_WAIT_IRQ = 3'd3,
        ST_RESP     = 3'd4
    } sched_state_e;

    // SPI core register offsets
    localparam logic [4:0] REG_RXTX = 5'h00;
    localparam logic [4:0] REG_CTRL = 5'h10;
    localparam logic [4:0] REG_DIV  = 5'h14;
    localparam logic [4:0] REG_SS   = 5'h18;

    // ctrl register bit positions
    localparam int CTRL_GO  = 8;
    localparam int CTRL_IE  = 12;
    localparam int CTRL_ASS = 13;

    // APB step index: which operation the current SETUP/ACCESS performs
    localparam logic [2:0] STEP_DIV  = 3'd0;
    localparam logic [2:0] STEP_SS   = 3'd1;
    localparam logic [2:0] STEP_TX   = 3'd2;
    localparam logic [2:0] STEP_CTRL = 3'd3;
    localparam logic [2:0] STEP_GO   = 3'd4;
    localparam logic [2:0] STEP_RX   = 3'd5;

    // ctrl word: char_len in [6:0], go, interrupt enable and auto slave select
    function automatic logic [31:0] make_ctrl(input logic [6:0] len, input logic go);
        logic [31:0] c;
        c           = '0;
        c[6:0]      = len;
        c[CTRL_GO]  = go;
        c[CTRL_IE]  = 1'b1;
        c[CTRL_ASS] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/spi_xfer_sched_if.sv
// spi_xfer_sched_if: APB bus plus interrupt line between the scheduler
// (master) and the SPI core (slave).
//
// Handshake: the master raises PSEL with PENABLE=0 for one SETUP cycle, then
// raises PENABLE and holds PADDR/PWDATA/PWRITE stable until it samples
// PREADY=1 on a rising PCLK edge; that edge completes the transfer, and
// PRDATA/PSLVERR are only meaningful in that same cycle. IRQ is a level
// from the core, sampled on PCLK.
interface spi_xfer_sched_if;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        IRQ;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR, IRQ
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR, IRQ
    );
endinterface

// File: rtl/spi_sched_rr_arb.sv
// spi_sched_rr_arb: combinational round-robin arbiter. The lowest requester
// strictly above last_i wins; if none, the search wraps to the lowest index.
module spi_sched_rr_arb
    import spi_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o
);

    logic [NREQ-1:0] w_above;
    logic [NREQ-1:0] w_masked;
    logic            w_found;

    // Mark requester slots strictly above the last grant
    always_comb begin
        w_above = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_above[i] = (i > int'(last_i));
        end
    end

    assign w_masked = req_i & w_above;

    // Pick the lowest masked request, otherwise wrap to the lowest raw request
    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        if (|w_masked) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && w_masked[i]) begin
                    gnt_o[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_i[i]) begin
                    gnt_o[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: arbitrates between NREQ requesters and runs one SPI
// character per grant through an APB-attached SPI core: DIV, SS, TX,
// ctrl (go=0), ctrl (go=1), wait for IRQ, read RX, then pulse done_o.
// Optional IRQ-wait timeout: define SPI_SCHED_TIMEOUT_EN.
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter logic [31:0] DIV_VAL = 32'd4,
    parameter int          TMO_CYC = 4096
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*32-1:0] req_tx_i,
    input  logic [NREQ*7-1:0]  req_len_i,
    input  logic [NREQ*8-1:0]  req_ss_i,
    output logic [NREQ-1:0]    done_o,
    output logic               err_o,
    output logic [31:0]        rdata_o,
    output sched_state_e       dbg_state_o,
    spi_xfer_sched_if.master   apb
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    // FSM
    sched_state_e    r_state;
    sched_state_e    w_state_nxt;
    logic [2:0]      r_step;
    logic [2:0]      w_step_nxt;

    // Arbitration and latched request context
    logic [NREQ-1:0] w_gnt_oh;
    logic [IW-1:0]   w_gnt_idx;
    logic [31:0]     w_sel_tx;
    logic [6:0]      w_sel_len;
    logic [7:0]      w_sel_ss;
    logic            w_grant;
    logic            r_busy;
    logic [IW-1:0]   r_last;
    logic [NREQ-1:0] r_gnt_oh;
    logic [31:0]     r_tx;
    logic [6:0]      r_len;
    logic [7:0]      r_ss;
    logic            r_err_acc;
    logic [31:0]     r_rdata;

    // Bus side
    logic            w_beat_done;
    logic            w_tmo_hit;
    logic            w_psel_nxt;
    logic            w_penable_nxt;
    logic            w_pwrite_nxt;
    logic [4:0]      w_paddr_nxt;
    logic [31:0]     w_pwdata_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic            w_err_nxt;
    logic            r_psel;
    logic            r_penable;
    logic            r_pwrite;
    logic [4:0]      r_paddr;
    logic [31:0]     r_pwdata;
    logic [NREQ-1:0] r_done;
    logic            r_err;

    spi_sched_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i  (req_i),
        .last_i (r_last),
        .gnt_o  (w_gnt_oh)
    );

    // Decode the one-hot grant into an index and pick that requester's fields
    always_comb begin
        w_gnt_idx = '0;
        w_sel_tx  = '0;
        w_sel_len = '0;
        w_sel_ss  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_gnt_idx = IW'(i);
                w_sel_tx  = req_tx_i[i*32 +: 32];
                w_sel_len = req_len_i[i*7 +: 7];
                w_sel_ss  = req_ss_i[i*8 +: 8];
            end
        end
    end

    // A grant only happens while idle between whole transfers
    assign w_grant     = (r_state == ST_IDLE) && !r_busy && (|w_gnt_oh);
    assign w_beat_done = (r_state == ST_ACCESS) && apb.PREADY;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Count cycles spent in WAIT_IRQ; held at zero everywhere else
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_WAIT_IRQ) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // The last permitted WAIT_IRQ cycle without IRQ gives up on the core
    assign w_tmo_hit = (r_state == ST_WAIT_IRQ) && !apb.IRQ &&
                       (r_tmo_cnt == TW'(TMO_CYC - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next step; IDLE with r_busy set is the gap between beats
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            ST_IDLE: begin
                if (r_busy) begin
                    w_state_nxt = ST_SETUP;
                end else if (w_grant) begin
                    w_state_nxt = ST_SETUP;
                    w_step_nxt  = STEP_DIV;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    if (r_step == STEP_GO) begin
                        w_state_nxt = ST_WAIT_IRQ;
                        w_step_nxt  = STEP_RX;
                    end else if (r_step == STEP_RX) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_step_nxt  = r_step + 3'd1;
                    end
                end
            end
            ST_WAIT_IRQ: begin
                if (apb.IRQ) begin
                    w_state_nxt = ST_SETUP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = STEP_DIV;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = STEP_DIV;
            end
        endcase
    end

    // Output decode from the next state; address/data load on entry to SETUP
    always_comb begin
        w_psel_nxt    = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
        w_penable_nxt = (w_state_nxt == ST_ACCESS);
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_pwrite_nxt  = r_pwrite;
        if (w_state_nxt == ST_SETUP) begin
            w_pwrite_nxt = 1'b1;
            case (w_step_nxt)
                STEP_DIV: begin
                    w_paddr_nxt  = REG_DIV;
                    w_pwdata_nxt = DIV_VAL;
                end
                STEP_SS: begin
                    w_paddr_nxt  = REG_SS;
                    w_pwdata_nxt = {24'b0, r_ss};
                end
                STEP_TX: begin
                    w_paddr_nxt  = REG_RXTX;
                    w_pwdata_nxt = r_tx;
                end
                STEP_CTRL: begin
                    w_paddr_nxt  = REG_CTRL;
                    w_pwdata_nxt = make_ctrl(r_len, 1'b0);
                end
                STEP_GO: begin
                    w_paddr_nxt  = REG_CTRL;
                    w_pwdata_nxt = make_ctrl(r_len, 1'b1);
                end
                default: begin
                    w_paddr_nxt  = REG_RXTX;
                    w_pwdata_nxt = '0;
                    w_pwrite_nxt = 1'b0;
                end
            endcase
        end
        w_done_nxt = (w_state_nxt == ST_RESP) ? r_gnt_oh : '0;
        w_err_nxt  = (w_state_nxt == ST_RESP) &&
                     (r_err_acc || (w_beat_done && apb.PSLVERR) || w_tmo_hit);
    end

    // Register the bus and completion outputs
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Transfer context: step, grant bookkeeping, latched fields, error, RX word
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_step    <= STEP_DIV;
            r_busy    <= 1'b0;
            r_last    <= IW'(NREQ - 1);
            r_gnt_oh  <= '0;
            r_tx      <= '0;
            r_len     <= '0;
            r_ss      <= '0;
            r_err_acc <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_step <= w_step_nxt;
            if (w_grant) begin
                r_busy    <= 1'b1;
                r_last    <= w_gnt_idx;
                r_gnt_oh  <= w_gnt_oh;
                r_tx      <= w_sel_tx;
                r_len     <= w_sel_len;
                r_ss      <= w_sel_ss;
                r_err_acc <= 1'b0;
            end else if (w_beat_done && apb.PSLVERR) begin
                r_err_acc <= 1'b1;
            end
            if (r_state == ST_RESP) begin
                r_busy <= 1'b0;
            end
            if (w_beat_done && (r_step == STEP_RX)) begin
                r_rdata <= apb.PRDATA;
            end else if (w_tmo_hit) begin
                r_rdata <= '0;
            end
        end
    end

    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
    assign apb.PADDR   = r_paddr;
    assign apb.PWDATA  = r_pwdata;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: randomized bench for spi_xfer_sched with an APB SPI-core
// model (loopback RX = last TX write, programmable wait states, PSLVERR
// injection, delayed IRQ) and a transfer-level reference model.
module tb_spi_xfer_sched;

    localparam int          NREQ = 2;
    localparam logic [31:0] DIV  = 32'd4;
    localparam int          TMO  = 16;

    // ---------------- clock / reset ----------------
    logic PCLK    = 1'b0;
    logic PRESETN = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [NREQ-1:0]    req_i;
    logic [NREQ*32-1:0] req_tx_i;
    logic [NREQ*7-1:0]  req_len_i;
    logic [NREQ*8-1:0]  req_ss_i;
    logic [NREQ-1:0]    done_o;
    logic               err_o;
    logic [31:0]        rdata_o;
    logic [2:0]         dbg_state;

    spi_xfer_sched_if apb ();

    spi_xfer_sched #(
        .NREQ    (NREQ),
        .DIV_VAL (DIV),
        .TMO_CYC (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .req_i       (req_i),
        .req_tx_i    (req_tx_i),
        .req_len_i   (req_len_i),
        .req_ss_i    (req_ss_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .dbg_state_o (dbg_state),
        .apb         (apb)
    );

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];

    logic [31:0] s_tx  [NREQ];
    logic [6:0]  s_len [NREQ];
    logic [7:0]  s_ss  [NREQ];
    int          m_last;

    // core model knobs / state
    int          ws       = 0;
    logic        err_en   = 1'b0;
    logic [4:0]  err_addr = 5'h18;
    logic        irq_en   = 1'b1;
    int          irq_dly  = 2;
    int          irq_cnt  = 0;
    logic [31:0] core_tx  = '0;
    int          wcnt     = 0;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        s_wr;
    logic        prev_ready = 1'b0;
    logic        prev_wait  = 1'b0;
    time         go_t   = 0;
    time         done_t = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI core / APB slave model ----------------
    always @(negedge PCLK) begin
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        if (irq_cnt > 0) begin
            irq_cnt--;
            if (irq_cnt == 0) apb.IRQ = 1'b1;
        end
        if (prev_ready) chk("apb_psel_drop", {63'b0, apb.PSEL}, 64'd0);
        if (prev_wait)  chk("apb_enable_hold", {62'b0, apb.PSEL, apb.PENABLE}, 64'd3);
        prev_ready = 1'b0;
        prev_wait  = 1'b0;
        if (apb.PSEL && !apb.PENABLE) begin
            s_addr = apb.PADDR;
            s_data = apb.PWDATA;
            s_wr   = apb.PWRITE;
            wcnt   = 0;
        end else if (apb.PSEL && apb.PENABLE) begin
            chk("apb_addr_stable", {59'b0, apb.PADDR}, {59'b0, s_addr});
            chk("apb_data_stable", {32'b0, apb.PWDATA}, {32'b0, s_data});
            chk("apb_dir_stable", {63'b0, apb.PWRITE}, {63'b0, s_wr});
            if (wcnt < ws) begin
                wcnt++;
                prev_wait = 1'b1;
            end else begin
                apb.PREADY = 1'b1;
                prev_ready = 1'b1;
                if (err_en && apb.PADDR == err_addr) apb.PSLVERR = 1'b1;
                if (apb.PWRITE) begin
                    obs_q.push_back({1'b1, apb.PADDR, apb.PWDATA});
                    if (apb.PADDR == 5'h00) core_tx = apb.PWDATA;
                    if (apb.PADDR == 5'h10 && apb.PWDATA[8]) begin
                        go_t = $time;
                        if (irq_en) irq_cnt = irq_dly;
                    end
                end else begin
                    obs_q.push_back({1'b0, apb.PADDR, 32'h0});
                    apb.PRDATA = core_tx;
                    apb.IRQ    = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] req);
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic go);
        return 32'h0000_3000 | {25'b0, len} | (go ? 32'h0000_0100 : 32'h0);
    endfunction

    task automatic push_exp(input int g, input logic with_read);
        exp_q.push_back({1'b1, 5'h14, DIV});
        exp_q.push_back({1'b1, 5'h18, {24'b0, s_ss[g]}});
        exp_q.push_back({1'b1, 5'h00, s_tx[g]});
        exp_q.push_back({1'b1, 5'h10, ctrl_word(s_len[g], 1'b0)});
        exp_q.push_back({1'b1, 5'h10, ctrl_word(s_len[g], 1'b1)});
        if (with_read) exp_q.push_back({1'b0, 5'h00, 32'h0});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_fields();
        for (int i = 0; i < NREQ; i++) begin
            req_tx_i[i*32 +: 32] = s_tx[i];
            req_len_i[i*7 +: 7]  = s_len[i];
            req_ss_i[i*8 +: 8]   = s_ss[i];
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            s_tx[i]  = $urandom;
            s_len[i] = 7'($urandom_range(0, 127));
            s_ss[i]  = 8'($urandom_range(1, 255));
        end
        drive_fields();
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        irq_cnt    = 0;
        apb.IRQ    = 1'b0;
        prev_ready = 1'b0;
        prev_wait  = 1'b0;
        m_last     = NREQ - 1;
    endtask

    task automatic apply_reset();
        req_i   = '0;
        PRESETN = 1'b0;
        clear_model();
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);
    endtask

    // Wait for a completion and check it against the model
    task automatic wait_done(input int g, input logic err_exp, input logic [31:0] rd_exp,
                             input logic keep, input string tag);
        int n;
        n = 0;
        while (done_o == '0 && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        if (done_o == '0) begin
            chk({tag, "_done_timeout"}, 64'd0, 64'd1);
            return;
        end
        done_t = $time;
        if (!keep) req_i = '0;
        chk({tag, "_done"}, {62'b0, done_o}, 64'(1) << g);
        chk({tag, "_err"}, {63'b0, err_o}, {63'b0, err_exp});
        chk({tag, "_rdata"}, {32'b0, rdata_o}, {32'b0, rd_exp});
        chk({tag, "_nops"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_op%0d", tag, i), {26'b0, obs_q[i]}, {26'b0, exp_q[i]});
        end
        @(negedge PCLK);
        chk({tag, "_pulse1"}, {62'b0, done_o}, 64'd0);
        exp_q.delete();
        obs_q.delete();
    endtask

    // One transfer: fields are changed (and optionally req dropped) mid-flight
    task automatic do_xfer(input logic [NREQ-1:0] req, input logic drop, input logic tmo,
                           input string tag);
        int          g;
        logic        err_exp;
        logic [31:0] rd_exp;
        g       = rr_pick(m_last, req);
        m_last  = g;
        push_exp(g, !tmo);
        err_exp = tmo || err_en;
        rd_exp  = tmo ? 32'h0 : s_tx[g];
        irq_dly = $urandom_range(1, 5);
        req_i   = req;
        repeat (3) @(negedge PCLK);
        scramble();
        if (drop) req_i = '0;
        wait_done(g, err_exp, rd_exp, 1'b0, tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int g;
        time d;
        req_i       = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = '0;
        apb.IRQ     = 1'b0;
        scramble();
        clear_model();

        // reset values
        repeat (2) @(negedge PCLK);
        chk("rst_psel", {63'b0, apb.PSEL}, 64'd0);
        chk("rst_penable", {63'b0, apb.PENABLE}, 64'd0);
        chk("rst_pwrite", {63'b0, apb.PWRITE}, 64'd0);
        chk("rst_paddr", {59'b0, apb.PADDR}, 64'd0);
        chk("rst_pwdata", {32'b0, apb.PWDATA}, 64'd0);
        chk("rst_done", {62'b0, done_o}, 64'd0);
        chk("rst_err", {63'b0, err_o}, 64'd0);
        chk("rst_rdata", {32'b0, rdata_o}, 64'd0);
        PRESETN = 1'b1;
        @(negedge PCLK);

        // single request, loopback
        s_tx[0] = 32'hA5; s_len[0] = 7'd8; s_ss[0] = 8'h01;
        drive_fields();
        do_xfer(2'b01, 1'b0, 1'b0, "single");

        // randomized masks, wait states, mid-transfer req drop
        for (int k = 0; k < 8; k++) begin
            ws = $urandom_range(0, 2);
            do_xfer(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end
        ws = 0;

        // fairness with both requests held
        apply_reset();
        scramble();
        req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g      = rr_pick(m_last, 2'b11);
            m_last = g;
            push_exp(g, 1'b1);
            irq_dly = $urandom_range(1, 5);
            wait_done(g, 1'b0, s_tx[g], 1'b1, "fair");
        end
        req_i = '0;
        @(negedge PCLK);

        // wait-stated slave
        ws = 3;
        do_xfer(2'b10, 1'b0, 1'b0, "wait");
        ws = 0;

        // PSLVERR on the SS write
        err_en = 1'b1; err_addr = 5'h18;
        do_xfer(2'b01, 1'b0, 1'b0, "slverr");
        err_en = 1'b0;

        // reset while waiting for IRQ
        irq_en  = 1'b0;
        req_i   = 2'b01;
        n = 0;
        while (obs_q.size() < 5 && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        chk("mid_reached_wait", 64'(obs_q.size()), 64'd5);
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b0;
        req_i   = '0;
        #1;
        chk("mid_psel", {63'b0, apb.PSEL}, 64'd0);
        chk("mid_done", {62'b0, done_o}, 64'd0);
        chk("mid_rdata", {32'b0, rdata_o}, 64'd0);
        clear_model();
        repeat (2) @(negedge PCLK);
        chk("mid_done_hold", {62'b0, done_o}, 64'd0);
        PRESETN = 1'b1;
        irq_en  = 1'b1;
        @(negedge PCLK);
        do_xfer(2'b10, 1'b0, 1'b0, "post_rst");

`ifdef SPI_SCHED_TIMEOUT_EN
        // IRQ never arrives: expect timeout completion without RX read
        irq_en = 1'b0;
        do_xfer(2'b01, 1'b0, 1'b1, "tmo");
        d = (done_t - go_t) / 10;
        chk("tmo_latency", {63'b0, (d >= 16 && d <= 18)}, 64'd1);
        irq_en = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: got=running exp=finished");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_xfer_sched.md
SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter DIV_VAL, default 32'd4, divider value written before every transfer.
REQ-003 SHALL have parameter TMO_CYC, default 4096, IRQ-wait timeout in PCLK cycles.
REQ-004 SHALL have port PCLK, input, 1, sole clock.
REQ-005 SHALL have port PRESETN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_i, input, NREQ, per-requester transfer request, level.
REQ-007 SHALL have port req_tx_i, input, NREQ*32, per-requester TX word.
REQ-008 SHALL have port req_len_i, input, NREQ*7, per-requester char length; 0 means 128 bits.
REQ-009 SHALL have port req_ss_i, input, NREQ*8, per-requester slave-select mask.
REQ-010 SHALL have port done_o, output, NREQ, one-cycle completion pulse per requester.
REQ-011 SHALL have port err_o, output, 1, qualifies done_o with error.
REQ-012 SHALL have port rdata_o, output, 32, RX word, valid with done_o.
REQ-013 SHALL have ports PADDR (output, 5), PWDATA (output, 32), PWRITE (output, 1), PSEL (output, 1) and PENABLE (output, 1): APB master toward the SPI core.
REQ-014 SHALL have ports PRDATA (input, 32), PREADY (input, 1), PSLVERR (input, 1) and IRQ (input, 1) from the SPI core.

Function
REQ-015 SHALL use a round-robin arbiter in IDLE: grant the lowest index above the last grant that has req_i high, wrapping around; after reset the last grant SHALL be NREQ-1, so index 0 wins first.
REQ-016 SHALL latch the granted requester's tx, len and ss values in the grant cycle; later changes to them SHALL be ignored until done.
REQ-017 SHALL use the FSM states IDLE, SETUP, ACCESS, WAIT_IRQ, RESP, with a 3-bit step index selecting the APB operation.
REQ-018 SHALL issue this APB sequence, in order:
- write 0x14 = DIV_VAL
- write 0x18 = {24'b0, ss}
- write 0x00 = tx
- write 0x10 = ctrl with go=0
- write 0x10 = ctrl with go=1
- wait for IRQ
- read 0x00
REQ-019 SHALL form ctrl as char_len[6:0] = len, go at bit 8, ie at bit 12 = 1, ass at bit 13 = 1, with all other bits 0.
REQ-020 SHALL use standard APB timing: SETUP drives PSEL=1, PENABLE=0 for one cycle; ACCESS holds PSEL=1, PENABLE=1 and stable address/data until PREADY=1; PSEL and PENABLE SHALL drop in the cycle after PREADY.
REQ-021 SHALL go from IDLE to SETUP one cycle after grant, with no back-to-back APB transfers and at least one idle cycle between them.
REQ-022 SHALL enter WAIT_IRQ after the go=1 write completes, and leave it on the first PCLK edge that samples IRQ=1.
REQ-023 SHALL capture PRDATA into rdata_o when the RX read's ACCESS completes with PREADY.
REQ-024 SHALL, in RESP, pulse done_o[grant] for exactly one cycle and then return to IDLE, so the next grant is earliest in the following cycle.
REQ-025 SHALL record PSLVERR=1 sampled with PREADY, continue the sequence, and assert err_o with done_o.
REQ-026 SHALL ignore req_i deasserted mid-transfer; the transfer completes and done_o still pulses.
REQ-027 SHALL hold rdata_o until the next capture.

Reset
REQ-028 SHALL, with PRESETN low, asynchronously clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, done_o, err_o and rdata_o to 0, set the state to IDLE and the step index to 0.
REQ-029 SHALL, on reset mid-transfer, abandon the transfer with no done_o pulse, and start the first transfer after release at step 0.

Configuration
REQ-030 SHALL implement the timeout only when SPI_SCHED_TIMEOUT_EN is defined: a counter runs in WAIT_IRQ, and if it reaches TMO_CYC without IRQ the block skips the RX read, goes to RESP with err_o=1 and rdata_o=0, and the counter clears on entering WAIT_IRQ.
REQ-031 SHALL, with SPI_SCHED_TIMEOUT_EN undefined, wait in WAIT_IRQ indefinitely and include no counter logic.

Structure
REQ-032 SHALL place in package spi_sched_pkg: the state enum, the register offsets (0x00, 0x10, 0x14, 0x18), the ctrl bit positions (GO=8, IE=12, ASS=13) and the step encoding.
REQ-033 SHALL place the round-robin arbiter in sub-module spi_sched_rr_arb, with request vector and last-grant in, and one-hot grant out.

Verification
REQ-034 SHALL verify single request: req_i=01, tx=0xA5, len=8, ss=0x01, with the core looping MOSI to MISO -> APB writes 0x14/0x18/0x00/0x10/0x10, then read 0x00, done_o=01, rdata_o=0xA5, err_o=0.
REQ-035 SHALL verify fairness: req_i=11 held for 4 transfers -> grant order 0,1,0,1, and every done_o pulse is exactly one cycle.
REQ-036 SHALL verify a wait-stated slave: the model inserts 3 PREADY-low cycles per access -> PADDR/PWDATA stay stable and PENABLE stays high until PREADY.
REQ-037 SHALL verify PSLVERR: PSLVERR=1 on the SS write -> sequence completes, and done_o carries err_o=1.
REQ-038 SHALL verify reset mid-transfer: PRESETN low during WAIT_IRQ -> PSEL=0 immediately; after release a new req_i=10 completes normally with no stale done_o.
REQ-039 SHALL verify timeout (SPI_SCHED_TIMEOUT_EN defined, TMO_CYC=16): IRQ held 0 -> done_o after 16 cycles with err_o=1, rdata_o=0 and no RX read.
